tcx: RTL

Parametrised timer/counter, successor to the 8-bit two-channel timer on the peripheral register bus. Counter width, compare-channel count and base address are parameters. Adds fast and phase-correct PWM with buffered compare registers, a 16-bit atomic byte-access path, and a prioritised interrupt vector. Sits on the 8-bit peripheral bus beside the existing timer and uses the same interrupt request/executed handshake.

---
 rtl/tcx_pkg.sv | 41 ++++
 rtl/tcx_prescaler.sv | 52 +++++
 rtl/tcx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcx_pkg.sv
// Shared types and register map for the tcx timer/counter.
// Offsets are relative to the instance base address.
package tcx_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_PHASE  = 2'd1,
        MODE_CTC    = 2'd2,
        MODE_FAST   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        CS_STOP    = 3'd0,
        CS_CLK     = 3'd1,
        CS_DIV8    = 3'd2,
        CS_DIV64   = 3'd3,
        CS_DIV256  = 3'd4,
        CS_DIV1024 = 3'd5,
        CS_T0_FALL = 3'd6,
        CS_T0_RISE = 3'd7
    } cs_e;

    typedef enum logic [1:0] {
        COM_OFF    = 2'd0,
        COM_TOGGLE = 2'd1,
        COM_CLEAR  = 2'd2,
        COM_SET    = 2'd3
    } com_e;

    localparam logic [7:0] OFF_TCCRA = 8'd0;
    localparam logic [7:0] OFF_TCCRB = 8'd1;
    localparam logic [7:0] OFF_TCCRC = 8'd2;
    localparam logic [7:0] OFF_TIMSK = 8'd3;
    localparam logic [7:0] OFF_TIFR  = 8'd4;
    localparam logic [7:0] OFF_TCNTL = 8'd5;
    localparam logic [7:0] OFF_TCNTH = 8'd6;
    localparam logic [7:0] OFF_OCR   = 8'd8;

    localparam int TOV_BIT = 0;

endpackage

// File: rtl/tcx_prescaler.sv
// Clock prescaler and synchronised t0 edge detector; produces the one-cycle
// count tick selected by CS.
module tcx_prescaler
    import tcx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       presc_clr,
    input  logic [2:0] cs,
    input  logic       t0,
    output logic       tick
);
    logic [9:0] presc_reg;
    logic       t0_meta_reg;
    logic       t0_sync_reg;
    logic       t0_prev_reg;
    cs_e        cs_sel;

    assign cs_sel = cs_e'(cs);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg   <= '0;
            t0_meta_reg <= 1'b0;
            t0_sync_reg <= 1'b0;
            t0_prev_reg <= 1'b0;
        end else begin
            presc_reg   <= presc_clr ? 10'd0 : presc_reg + 10'd1;
            t0_meta_reg <= t0;
            t0_sync_reg <= t0_meta_reg;
            t0_prev_reg <= t0_sync_reg;
        end
    end

    // Counter restarts at 0 on a TCCRB write, so the first divided tick
    // lands exactly div cycles later.
    always_comb begin
        tick = 1'b0;
        case (cs_sel)
            CS_STOP:    tick = 1'b0;
            CS_CLK:     tick = 1'b1;
            CS_DIV8:    tick = &presc_reg[2:0];
            CS_DIV64:   tick = &presc_reg[5:0];
            CS_DIV256:  tick = &presc_reg[7:0];
            CS_DIV1024: tick = &presc_reg;
            CS_T0_FALL: tick = t0_prev_reg & ~t0_sync_reg;
            CS_T0_RISE: tick = t0_sync_reg & ~t0_prev_reg;
            default:    tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/tcx.sv
// Timer/counter with compare channels, PWM modes, buffered compare registers,
// 16-bit TEMP byte access and a prioritised interrupt vector.
module tcx
    import tcx_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter int         NCH   = 2,
    parameter logic [7:0] BASE  = 8'h24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           write,
    input  logic [7:0]     addr,
    input  logic [7:0]     wdata,
    input  logic           read,
    output logic [7:0]     rdata,
    input  logic           t0,
    output logic [NCH-1:0] oc_data,
    input  logic           status_reg_interrupt_enable,
    output logic           interrupt_request,
    output logic [2:0]     irq_vector,
    input  logic           interrupt_executed
);
    localparam int               NFLAG = NCH + 1;
    localparam logic [WIDTH-1:0] MAX   = '1;

    logic [1:0]         mode_reg;
    logic [2:0]         cs_reg;
    logic [2*NCH-1:0]   com_reg;
    logic [NFLAG-1:0]   timsk_reg, tifr_reg, tifr_next;
    logic [WIDTH-1:0]   tcnt_reg, tcnt_next;
    logic [7:0]         temp_reg, rdata_reg;
    logic               down_reg, down_next, skip_reg;
    logic [NCH-1:0]     oc_reg, oc_next, match;
    logic [NCH*WIDTH-1:0] ocr_flat, ocr_buf_flat;

    logic [8:0]       rel;
    logic [7:0]       off;
    logic             hit, wr_en, wr_hi, tcnt_wr, tick;
    logic [WIDTH-1:0] wr_word;
    logic             at_max, wrap_evt, buf_load, pwm_mode, tov_set;
    mode_e            mode;

    assign rel      = {1'b0, addr} - {1'b0, BASE};
    assign hit      = !rel[8] && (rel < 9'(OFF_OCR + 2 * NCH));
    assign off      = rel[7:0];
    assign wr_en    = write && hit;
    assign wr_hi    = wr_en && (off == OFF_TCNTH || (off >= OFF_OCR && off[0]));
    assign tcnt_wr  = wr_en && off == OFF_TCNTL;
    assign wr_word  = WIDTH'({temp_reg, wdata});
    assign mode     = mode_e'(mode_reg);
    assign pwm_mode = (mode == MODE_FAST) || (mode == MODE_PHASE);
    assign at_max   = tcnt_reg == MAX;
    assign wrap_evt = tick && at_max;
    assign buf_load = wrap_evt && pwm_mode;

    tcx_prescaler u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .presc_clr (wr_en && off == OFF_TCCRB),
        .cs        (cs_reg),
        .t0        (t0),
        .tick      (tick)
    );

    always_comb begin
        tcnt_next = tcnt_reg;
        down_next = (mode == MODE_PHASE) ? down_reg : 1'b0;
        tov_set   = 1'b0;
        if (tick) begin
            case (mode)
                MODE_PHASE: begin
                    if (!down_reg) begin
                        down_next = at_max;
                        tcnt_next = at_max ? tcnt_reg - WIDTH'(1) : tcnt_reg + WIDTH'(1);
                    end else if (tcnt_reg == '0) begin
                        down_next = 1'b0;
                        tcnt_next = WIDTH'(1);
                        tov_set   = 1'b1;
                    end else begin
                        tcnt_next = tcnt_reg - WIDTH'(1);
                    end
                end
                // Only an exact hit on OCR0 restarts; past it the count runs to MAX.
                MODE_CTC: begin
                    tcnt_next = (tcnt_reg == ocr_flat[WIDTH-1:0]) ? '0 : tcnt_reg + WIDTH'(1);
                    tov_set   = at_max;
                end
                default: begin
                    tcnt_next = tcnt_reg + WIDTH'(1);
                    tov_set   = at_max;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] ocr_reg, ocr_buf_reg;
            logic             ocr_wr, oc_n;
            com_e             com;

            assign com    = com_e'(com_reg[2*gi +: 2]);
            assign ocr_wr = wr_en && off == 8'(OFF_OCR + 2 * gi);
            assign match[gi] = tick && !skip_reg && tcnt_reg == ocr_reg;
            assign oc_next[gi] = oc_n;
            assign ocr_flat[gi*WIDTH +: WIDTH]     = ocr_reg;
            assign ocr_buf_flat[gi*WIDTH +: WIDTH] = ocr_buf_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ocr_reg     <= '0;
                    ocr_buf_reg <= '0;
                end else begin
                    if (ocr_wr) ocr_buf_reg <= wr_word;
                    if (ocr_wr && !pwm_mode) ocr_reg <= wr_word;
                    else if (buf_load)       ocr_reg <= ocr_buf_reg;
                end
            end

            always_comb begin
                oc_n = oc_reg[gi];
                if (com == COM_OFF) begin
                    oc_n = 1'b0;
                end else if (mode == MODE_FAST && wrap_evt && com != COM_TOGGLE) begin
                    oc_n = (com == COM_CLEAR);
                end else if (match[gi]) begin
                    if (com == COM_TOGGLE)       oc_n = !oc_reg[gi];
                    else if (mode == MODE_PHASE) oc_n = (com == COM_CLEAR) ? down_reg : !down_reg;
                    else                         oc_n = (com == COM_SET);
                end
            end
        end
    endgenerate

    logic [NFLAG-1:0] pending, sel_mask, clr_mask;
    logic [2:0]       vec;

    // Lowest-index compare flag wins; TOV only when no compare flag is pending.
    always_comb begin
        pending  = tifr_reg & timsk_reg;
        vec      = 3'd0;
        sel_mask = '0;
        if (pending[TOV_BIT]) begin
            vec      = 3'(NCH);
            sel_mask[TOV_BIT] = 1'b1;
        end
        for (int n = NCH - 1; n >= 0; n--) begin
            if (pending[n+1]) begin
                vec      = 3'(n);
                sel_mask = '0;
                sel_mask[n+1] = 1'b1;
            end
        end
    end

    assign interrupt_request = status_reg_interrupt_enable && |pending;
    assign irq_vector        = vec;

    always_comb begin
        clr_mask = '0;
        if (wr_en && off == OFF_TIFR)                clr_mask = wdata[NFLAG-1:0];
        if (interrupt_executed && interrupt_request) clr_mask = clr_mask | sel_mask;
        tifr_next = (tifr_reg & ~clr_mask) | {match, tov_set};
    end

    logic [7:0] rd_byte, rd_hi;
    logic       rd_lo;
    logic [15:0] tcnt16;

    assign tcnt16 = 16'(tcnt_reg);

    always_comb begin
        rd_byte = 8'd0;
        rd_hi   = 8'd0;
        rd_lo   = 1'b0;
        if (hit) begin
            case (off)
                OFF_TCCRA: rd_byte = {6'd0, mode_reg};
                OFF_TCCRB: rd_byte = {5'd0, cs_reg};
                OFF_TCCRC: rd_byte = 8'(com_reg);
                OFF_TIMSK: rd_byte = 8'(timsk_reg);
                OFF_TIFR:  rd_byte = 8'(tifr_reg);
                OFF_TCNTL: begin
                    rd_byte = tcnt16[7:0];
                    rd_hi   = tcnt16[15:8];
                    rd_lo   = 1'b1;
                end
                OFF_TCNTH: rd_byte = (WIDTH == 16) ? temp_reg : 8'd0;
                default:   rd_byte = 8'd0;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (off == 8'(OFF_OCR + 2 * n)) begin
                    rd_byte = 8'(ocr_buf_flat[n*WIDTH +: WIDTH]);
                    rd_hi   = 8'(16'(ocr_buf_flat[n*WIDTH +: WIDTH]) >> 8);
                    rd_lo   = 1'b1;
                end
                if (off == 8'(OFF_OCR + 2 * n + 1)) rd_byte = (WIDTH == 16) ? temp_reg : 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg  <= '0;
            cs_reg    <= '0;
            com_reg   <= '0;
            timsk_reg <= '0;
            tifr_reg  <= '0;
            tcnt_reg  <= '0;
            temp_reg  <= '0;
            rdata_reg <= '0;
            down_reg  <= 1'b0;
            skip_reg  <= 1'b0;
            oc_reg    <= '0;
        end else begin
            if (wr_en) begin
                case (off)
                    OFF_TCCRA: mode_reg  <= wdata[1:0];
                    OFF_TCCRB: cs_reg    <= wdata[2:0];
                    OFF_TCCRC: com_reg   <= wdata[2*NCH-1:0];
                    OFF_TIMSK: timsk_reg <= wdata[NFLAG-1:0];
                    default: ;
                endcase
            end
            tifr_reg <= tifr_next;
            down_reg <= down_next;
            oc_reg   <= oc_next;
            // A software load masks the compare on the tick that follows it.
            if (tcnt_wr) begin
                tcnt_reg <= wr_word;
                skip_reg <= 1'b1;
            end else begin
                tcnt_reg <= tcnt_next;
                if (tick) skip_reg <= 1'b0;
            end
            if (WIDTH == 16) begin
                if (wr_hi)             temp_reg <= wdata;
                else if (read && rd_lo) temp_reg <= rd_hi;
            end
            if (read) rdata_reg <= rd_byte;
        end
    end

    assign rdata   = rdata_reg;
    assign oc_data = oc_reg;

endmodule
